grf_wb_ctrl: RTL and testbench

Writeback controller that drives the write side of the 1-write/2-read general register file. It accepts results from the ALU path and the load path through valid/ready handshakes, and formats load data (byte/half extract, sign/zero extend, or lane insert). It buffers results in a small FIFO and presents one register write per enabled cycle on the regfile write pins. It also exports a per-register pending-write scoreboard for issue hazard checks.

---
 rtl/grf_wb_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_grf_wb_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_ctrl.sv
// grf_wb_ctrl: writeback controller for the 1W/2R general register file.
// Accepts ALU and load results over valid/ready, formats load data, queues
// writes in a small FIFO and presents one registered write per enabled cycle.
// Also exports a per-register pending-write scoreboard (o_busy).
//
// Build option: define GRF_WB_R0_ZERO_EN to make R0 hard-wired to zero
// (rd=0 results are accepted but dropped; o_busy[0] stays 0).
module grf_wb_ctrl #(
    parameter int DEPTH = 2,
    parameter int AW    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_b,
    input  logic                 i_clk_en,
    input  logic                 i_alu_valid,
    output logic                 o_alu_ready,
    input  logic [AW-1:0]        i_alu_rd,
    input  logic [31:0]          i_alu_data,
    input  logic                 i_ld_valid,
    output logic                 o_ld_ready,
    input  logic [AW-1:0]        i_ld_rd,
    input  logic [31:0]          i_ld_data,
    input  logic [1:0]           i_ld_size,
    input  logic [1:0]           i_ld_off,
    input  logic                 i_ld_sext,
    input  logic                 i_ld_ins,
    output logic [AW-1:0]        o_waddr,
    output logic [3:0]           o_wen,
    output logic                 o_cs_b,
    output logic [31:0]          o_din,
    output logic [(1<<AW)-1:0]   o_busy,
    output logic                 o_empty
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NREG = 1 << AW;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [3:0]    wen;
        logic [31:0]   data;
    } wb_entry_t;

    // FIFO storage and control
    wb_entry_t      mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q, count_d;
    // Round-robin pointer: 1 = load side wins the next contested cycle
    logic           rr_ld_q, rr_ld_d;

    // Registered write port
    logic           cs_b_q, cs_b_d;
    logic [AW-1:0]  waddr_q, waddr_d;
    logic [3:0]     wen_q, wen_d;
    logic [31:0]    din_q, din_d;

    logic           pop, space, push, accept, acc_alu, acc_ld, contested, drop_r0;
    logic           alu_ready, ld_ready;
    wb_entry_t      head, alu_entry, ld_entry, push_entry;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [3:0]     ld_wen;
    logic [31:0]    ld_fmt;
    logic [DEPTH-1:0] entry_vld;
    logic [NREG-1:0]  busy;

    assign head = mem_q[rd_ptr_q];

    // A slot frees up this cycle if the head is being popped into the output stage
    assign pop   = i_clk_en && (count_q != '0);
    assign space = (count_q - {{PW{1'b0}}, pop}) < DEPTH_C;

    // The side not favoured by the pointer is held off only while the other side is valid
    assign alu_ready = space && (!i_ld_valid || !rr_ld_q);
    assign ld_ready  = space && (!i_alu_valid || rr_ld_q);
    assign acc_alu   = i_clk_en && i_alu_valid && alu_ready;
    assign acc_ld    = i_clk_en && i_ld_valid && ld_ready;
    assign accept    = acc_alu || acc_ld;
    assign contested = i_alu_valid && i_ld_valid && accept;

    assign o_alu_ready = alu_ready;
    assign o_ld_ready  = ld_ready;

    // Load lane extraction and enable generation
    always_comb begin
        case (i_ld_off)
            2'd0:    ld_byte = i_ld_data[7:0];
            2'd1:    ld_byte = i_ld_data[15:8];
            2'd2:    ld_byte = i_ld_data[23:16];
            default: ld_byte = i_ld_data[31:24];
        endcase
        ld_half = i_ld_off[1] ? i_ld_data[31:16] : i_ld_data[15:0];
        ld_fmt  = i_ld_data;
        ld_wen  = 4'b1111;
        if (i_ld_ins) begin
            // Partial write: data stays in place, the regfile merges other lanes
            case (i_ld_size)
                2'b00:   ld_wen = 4'b0001 << i_ld_off;
                2'b01:   ld_wen = i_ld_off[1] ? 4'b1100 : 4'b0011;
                default: ld_wen = 4'b1111;
            endcase
        end else begin
            case (i_ld_size)
                2'b00:   ld_fmt = {{24{i_ld_sext & ld_byte[7]}}, ld_byte};
                2'b01:   ld_fmt = {{16{i_ld_sext & ld_half[15]}}, ld_half};
                default: ld_fmt = i_ld_data;
            endcase
        end
    end

    assign alu_entry  = '{rd: i_alu_rd, wen: 4'b1111, data: i_alu_data};
    assign ld_entry   = '{rd: i_ld_rd, wen: ld_wen, data: ld_fmt};
    assign push_entry = acc_ld ? ld_entry : alu_entry;

`ifdef GRF_WB_R0_ZERO_EN
    assign drop_r0 = (push_entry.rd == '0);
`else
    assign drop_r0 = 1'b0;
`endif

    assign push = accept && !drop_r0;

    // Next-state for FIFO pointers, arbitration pointer and output stage
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rr_ld_d  = rr_ld_q;
        cs_b_d   = cs_b_q;
        waddr_d  = waddr_q;
        wen_d    = wen_q;
        din_d    = din_q;
        if (i_clk_en) begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                cs_b_d   = 1'b0;
                waddr_d  = head.rd;
                wen_d    = head.wen;
                din_d    = head.data;
            end else begin
                // Nothing to write: strobe off, address/data hold
                cs_b_d = 1'b1;
                wen_d  = 4'b0000;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
            if (contested) begin
                rr_ld_d = ~rr_ld_q;
            end
        end
    end

    // FIFO payload storage; validity is tracked by the pointers, so no reset
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Control and output-stage registers
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_ld_q  <= 1'b1;
            cs_b_q   <= 1'b1;
            waddr_q  <= '0;
            wen_q    <= '0;
            din_q    <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rr_ld_q  <= rr_ld_d;
            cs_b_q   <= cs_b_d;
            waddr_q  <= waddr_d;
            wen_q    <= wen_d;
            din_q    <= din_d;
        end
    end

    // An entry is live if its distance from the read pointer is below the count
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_vld
            logic [PW-1:0] rel;
            assign rel           = PW'(gi) - rd_ptr_q;
            assign entry_vld[gi] = ({1'b0, rel} < count_q);
        end
    endgenerate

    // Scoreboard: OR of destinations of live FIFO entries and the presented write
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i]) begin
                busy[mem_q[i].rd] = 1'b1;
            end
        end
        if (!cs_b_q) begin
            busy[waddr_q] = 1'b1;
        end
`ifdef GRF_WB_R0_ZERO_EN
        busy[0] = 1'b0;
`endif
    end

    assign o_busy  = busy;
    assign o_empty = (count_q == '0) && cs_b_q;
    assign o_cs_b  = cs_b_q;
    assign o_waddr = waddr_q;
    assign o_wen   = wen_q;
    assign o_din   = din_q;

endmodule

// File: tb/tb_grf_wb_ctrl.sv
// tb_grf_wb_ctrl: directed bench for grf_wb_ctrl with a queue-based reference
// model and a per-cycle compare process, plus literal spot checks.
module tb_grf_wb_ctrl;

    localparam int DEPTH = 2;

    logic        i_clk, i_rst_b, i_clk_en;
    logic        i_alu_valid, o_alu_ready;
    logic [3:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        i_ld_valid, o_ld_ready;
    logic [3:0]  i_ld_rd;
    logic [31:0] i_ld_data;
    logic [1:0]  i_ld_size, i_ld_off;
    logic        i_ld_sext, i_ld_ins;
    logic [3:0]  o_waddr, o_wen;
    logic        o_cs_b;
    logic [31:0] o_din;
    logic [15:0] o_busy;
    logic        o_empty;

    grf_wb_ctrl #(.DEPTH(DEPTH), .AW(4)) dut (
        .i_clk(i_clk), .i_rst_b(i_rst_b), .i_clk_en(i_clk_en),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
        .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
        .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data), .i_ld_size(i_ld_size),
        .i_ld_off(i_ld_off), .i_ld_sext(i_ld_sext), .i_ld_ins(i_ld_ins),
        .o_waddr(o_waddr), .o_wen(o_wen), .o_cs_b(o_cs_b), .o_din(o_din),
        .o_busy(o_busy), .o_empty(o_empty)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

`ifdef GRF_WB_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  rd;
        logic [3:0]  wen;
        logic [31:0] data;
    } wr_t;

    wr_t mq[$];
    wr_t m_out;
    bit  m_pres;
    bit  m_rr_ld;
    bit  m_acc_alu, m_acc_ld;

    function automatic wr_t fmt_ld(input logic [3:0] rd, input logic [31:0] d,
                                   input logic [1:0] sz, input logic [1:0] off,
                                   input logic sx, input logic ins);
        wr_t r;
        logic [31:0] v;
        r.rd = rd; r.wen = 4'hF; r.data = d;
        if (ins) begin
            if (sz == 2'd0)      r.wen = 4'(1 << off);
            else if (sz == 2'd1) r.wen = off[1] ? 4'b1100 : 4'b0011;
        end else if (sz == 2'd0) begin
            v = (d >> (8 * off)) & 32'hFF;
            if (sx && v[7]) v = v | 32'hFFFF_FF00;
            r.data = v;
        end else if (sz == 2'd1) begin
            v = (d >> (16 * off[1])) & 32'hFFFF;
            if (sx && v[15]) v = v | 32'hFFFF_0000;
            r.data = v;
        end
        return r;
    endfunction

    function automatic bit m_space();
        int n = mq.size();
        int p = (i_clk_en && n > 0) ? 1 : 0;
        return (n - p) < DEPTH;
    endfunction

    wr_t nw;
    always @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            mq.delete();
            m_pres = 1'b0; m_out = '0; m_rr_ld = 1'b1;
            m_acc_alu = 1'b0; m_acc_ld = 1'b0;
        end else begin
            m_acc_alu = 1'b0; m_acc_ld = 1'b0;
            if (i_clk_en) begin
                if (m_space()) begin
                    if (i_alu_valid && i_ld_valid) begin
                        if (m_rr_ld) m_acc_ld = 1'b1; else m_acc_alu = 1'b1;
                        m_rr_ld = !m_rr_ld;
                    end else if (i_ld_valid) m_acc_ld = 1'b1;
                    else if (i_alu_valid)    m_acc_alu = 1'b1;
                end
                if (mq.size() > 0) begin
                    m_out  = mq.pop_front();
                    m_pres = 1'b1;
                end else begin
                    m_pres = 1'b0;
                end
                if (m_acc_ld)
                    nw = fmt_ld(i_ld_rd, i_ld_data, i_ld_size, i_ld_off, i_ld_sext, i_ld_ins);
                else
                    nw = '{rd: i_alu_rd, wen: 4'hF, data: i_alu_data};
                if ((m_acc_ld || m_acc_alu) && !(R0Z && nw.rd == 4'd0))
                    mq.push_back(nw);
            end
        end
    end

    // Compare every cycle, away from the active edge
    logic [15:0] exp_busy;
    always @(negedge i_clk) begin
        exp_busy = '0;
        foreach (mq[k]) exp_busy[mq[k].rd] = 1'b1;
        if (m_pres) exp_busy[m_out.rd] = 1'b1;
        chk("cyc_cs_b",  {31'd0, o_cs_b},  {31'd0, !m_pres});
        chk("cyc_wen",   {28'd0, o_wen},   {28'd0, (m_pres ? m_out.wen : 4'h0)});
        chk("cyc_waddr", {28'd0, o_waddr}, {28'd0, m_out.rd});
        chk("cyc_din",   o_din,            m_out.data);
        chk("cyc_busy",  {16'd0, o_busy},  {16'd0, exp_busy});
        chk("cyc_empty", {31'd0, o_empty}, {31'd0, (mq.size() == 0 && !m_pres)});
        chk("cyc_alu_rdy", {31'd0, o_alu_ready},
            {31'd0, (m_space() && (!i_ld_valid || !m_rr_ld))});
        chk("cyc_ld_rdy", {31'd0, o_ld_ready},
            {31'd0, (m_space() && (!i_alu_valid || m_rr_ld))});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_alu_valid = 1'b0;
        i_ld_valid  = 1'b0;
    endtask

    task automatic set_alu(input logic [3:0] rd, input logic [31:0] d);
        i_alu_valid = 1'b1; i_alu_rd = rd; i_alu_data = d;
    endtask

    task automatic set_ld(input logic [3:0] rd, input logic [31:0] d, input logic [1:0] sz,
                          input logic [1:0] off, input logic sx, input logic ins);
        i_ld_valid = 1'b1; i_ld_rd = rd; i_ld_data = d;
        i_ld_size = sz; i_ld_off = off; i_ld_sext = sx; i_ld_ins = ins;
    endtask

    int li, ai, cyc;
    logic [3:0] ld_rds [2];
    logic [3:0] alu_rds [2];
    int got_addr[$];
    int got_cyc[$];

    initial begin
        i_rst_b = 1'b0; i_clk_en = 1'b1;
        i_alu_valid = 0; i_alu_rd = 0; i_alu_data = 0;
        i_ld_valid = 0; i_ld_rd = 0; i_ld_data = 0;
        i_ld_size = 0; i_ld_off = 0; i_ld_sext = 0; i_ld_ins = 0;
        tick(); tick();
        chk("rst_cs_b",  {31'd0, o_cs_b},  32'd1);
        chk("rst_wen",   {28'd0, o_wen},   32'd0);
        chk("rst_waddr", {28'd0, o_waddr}, 32'd0);
        chk("rst_din",   o_din,            32'd0);
        chk("rst_busy",  {16'd0, o_busy},  32'd0);
        chk("rst_empty", {31'd0, o_empty}, 32'd1);
        i_rst_b = 1'b1;
        tick();

        // Contested arbitration first, while the pointer still favours load
        ld_rds[0] = 4'd1; ld_rds[1] = 4'd3;
        alu_rds[0] = 4'd2; alu_rds[1] = 4'd4;
        li = 0; ai = 0;
        set_ld(ld_rds[0], 32'h1111_1111, 2'd2, 2'd0, 1'b0, 1'b0);
        set_alu(alu_rds[0], 32'h2222_2222);
        for (cyc = 0; cyc < 7; cyc++) begin
            tick();
            if (m_acc_ld)  li++;
            if (m_acc_alu) ai++;
            if (li < 2) set_ld(ld_rds[li], 32'h1111_1111 * (li * 2 + 1), 2'd2, 2'd0, 1'b0, 1'b0);
            else        i_ld_valid = 1'b0;
            if (ai < 2) set_alu(alu_rds[ai], 32'h1111_1111 * (ai * 2 + 2));
            else        i_alu_valid = 1'b0;
            if (!o_cs_b) begin
                got_addr.push_back(int'(o_waddr));
                got_cyc.push_back(cyc);
            end
        end
        chk("arb_count", got_addr.size(), 32'd4);
        for (int k = 0; k < 4 && k < got_addr.size(); k++) begin
            chk("arb_order", got_addr[k], k + 1);
            chk("arb_cycle", got_cyc[k], k + 1);
        end
        idle(); tick();

        // ALU write latency and scoreboard
        set_alu(4'd3, 32'hDEAD_BEEF);
        tick();
        idle();
        chk("t1_busy_q", {16'd0, o_busy}, 32'h0008);
        tick();
        chk("t1_cs_b",  {31'd0, o_cs_b},  32'd0);
        chk("t1_waddr", {28'd0, o_waddr}, 32'd3);
        chk("t1_wen",   {28'd0, o_wen},   32'hF);
        chk("t1_din",   o_din,            32'hDEAD_BEEF);
        chk("t1_busy",  {16'd0, o_busy},  32'h0008);
        tick();
        chk("t1_done_cs_b",  {31'd0, o_cs_b},  32'd1);
        chk("t1_done_empty", {31'd0, o_empty}, 32'd1);
        chk("t1_done_busy",  {16'd0, o_busy},  32'd0);
        chk("t1_hold_din",   o_din,            32'hDEAD_BEEF);

        // Byte load, sign then zero extension
        set_ld(4'd5, 32'h11F0_2233, 2'd0, 2'd2, 1'b1, 1'b0);
        tick(); idle(); tick();
        chk("ldb_sx_din", o_din, 32'hFFFF_FFF0);
        chk("ldb_sx_wen", {28'd0, o_wen}, 32'hF);
        set_ld(4'd5, 32'h11F0_2233, 2'd0, 2'd2, 1'b0, 1'b0);
        tick(); idle(); tick();
        chk("ldb_zx_din", o_din, 32'h0000_00F0);

        // Lane inserts
        set_ld(4'd9, 32'hABCD_0000, 2'd1, 2'd2, 1'b0, 1'b1);
        tick(); idle(); tick();
        chk("insh_wen", {28'd0, o_wen}, 32'hC);
        chk("insh_din", o_din, 32'hABCD_0000);
        set_ld(4'd10, 32'h0000_AB00, 2'd0, 2'd1, 1'b0, 1'b1);
        tick(); idle(); tick();
        chk("insb_wen", {28'd0, o_wen}, 32'h2);
        chk("insb_din", o_din, 32'h0000_AB00);
        tick();

        // Stall with one write presented and one queued
        set_alu(4'd6, 32'h0000_0066);
        tick(); idle();
        set_ld(4'd7, 32'h7777_7777, 2'd2, 2'd0, 1'b0, 1'b0);
        tick(); idle();
        i_clk_en = 1'b0;
        set_alu(4'd8, 32'h8888_8888);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_cs_b",  {31'd0, o_cs_b},  32'd0);
            chk("stall_waddr", {28'd0, o_waddr}, 32'd6);
            chk("stall_busy",  {16'd0, o_busy},  32'h00C0);
        end
        i_clk_en = 1'b1;
        tick(); idle();
        chk("resume_waddr", {28'd0, o_waddr}, 32'd7);
        chk("resume_busy",  {16'd0, o_busy},  32'h0180);
        tick();
        chk("resume_c_waddr", {28'd0, o_waddr}, 32'd8);
        chk("resume_c_din",   o_din,            32'h8888_8888);
        tick();

        // Format sweep at full rate, checked by the model every cycle
        for (int sz = 0; sz < 4; sz++)
            for (int off = 0; off < 4; off++)
                for (int f = 0; f < 4; f++) begin
                    set_ld(4'(off * 4 + f), 32'h8F7E_A5C3 ^ (32'h0101_0101 * sz),
                           2'(sz), 2'(off), f[0], f[1]);
                    tick();
                end
        idle(); tick(); tick();

        // R0 handling
        set_alu(4'd0, 32'h1234_5678);
        #1;
        chk("r0_ready", {31'd0, o_alu_ready}, 32'd1);
        tick(); idle(); tick();
        if (R0Z) begin
            chk("r0_cs_b", {31'd0, o_cs_b}, 32'd1);
            chk("r0_busy", {16'd0, o_busy}, 32'd0);
        end else begin
            chk("r0_cs_b",  {31'd0, o_cs_b},  32'd0);
            chk("r0_waddr", {28'd0, o_waddr}, 32'd0);
        end
        tick();

        // Reset mid-operation discards everything
        set_alu(4'd11, 32'hBBBB_0011);
        tick();
        set_alu(4'd12, 32'hCCCC_0012);
        tick(); idle();
        #2 i_rst_b = 1'b0;
        #1;
        chk("mrst_cs_b",  {31'd0, o_cs_b},  32'd1);
        chk("mrst_wen",   {28'd0, o_wen},   32'd0);
        chk("mrst_busy",  {16'd0, o_busy},  32'd0);
        chk("mrst_empty", {31'd0, o_empty}, 32'd1);
        chk("mrst_din",   o_din,            32'd0);
        tick();
        i_rst_b = 1'b1;
        tick(); tick();
        chk("post_rst_cs_b",  {31'd0, o_cs_b},  32'd1);
        chk("post_rst_empty", {31'd0, o_empty}, 32'd1);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
